// File: rtl/mdu_seq_if.sv
// Pipeline-to-MDU bundle: start/operands/cancel, MTHI/MTLO writes, and status plus HI/LO read-back.
// The EX stage drives it through master; mdu_seq consumes it through slave.
interface mdu_seq_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             cancel;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, cancel, hi_we, lo_we, wdata,
        input  ready, busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, cancel, hi_we, lo_we, wdata,
        output ready, busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_seq.sv
// Multi-cycle MULT/MULTU (shift-add) and DIV/DIVU (restoring) sequencer owning HI/LO.
// Signed ops run on magnitudes; the sign is applied in a single FIX cycle.
//
// state  | meaning
// IDLE   | ready, waiting for start
// CALC   | one shift-add / restoring-divide iteration per cycle
// FIX    | sign fix-up, result written to HI/LO
// DONE   | one-cycle done pulse
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     resetn,
    mdu_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state;
    logic [CW-1:0]      counter;
    logic               div_q;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               is_signed;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [CW-1:0]      div_idx;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   trial;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        is_signed = ~bus.op[0];
        abs_a     = bus.src_a[WIDTH-1] ? -bus.src_a : bus.src_a;
        abs_b     = bus.src_b[WIDTH-1] ? -bus.src_b : bus.src_b;
    end

    // Operands stay untouched during CALC; bits are picked by counter so the
    // latched dividend is still available for the divide-by-zero result.
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (op_b[counter] ? {1'b0, op_a} : '0);
        div_idx = CW'(WIDTH-1) - counter;
        rem_sh  = {acc[2*WIDTH-1:WIDTH], op_a[div_idx]};
        trial   = {1'b0, rem_sh} - {2'b00, op_b};
        if (div_q) begin
            if (trial[WIDTH+1])
                acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                acc_step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            counter <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            acc     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start && !bus.cancel) begin
                        div_q <= bus.op[1];
                        if (is_signed) begin
                            op_a  <= abs_a;
                            op_b  <= abs_b;
                            neg_q <= bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1];
                            neg_r <= bus.src_a[WIDTH-1];
                        end else begin
                            op_a  <= bus.src_a;
                            op_b  <= bus.src_b;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                        end
                        acc     <= '0;
                        counter <= '0;
                        state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (bus.cancel) begin
                        state <= S_IDLE;
                    end else begin
                        acc     <= acc_step;
                        counter <= counter + CW'(1);
                        if (counter == CW'(WIDTH-1))
                            state <= S_FIX;
                    end
                end
                S_FIX:   state <= bus.cancel ? S_IDLE : S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Result write is placed last so it overrides a same-edge MTHI/MTLO.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
            if (state == S_FIX && !bus.cancel) begin
                if (!div_q) begin
                    hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                    lo_q <= prod_fix[WIDTH-1:0];
                end else if (op_b == '0) begin
                    hi_q <= op_a;
                    lo_q <= '1;
                end else begin
                    hi_q <= rem_fix;
                    lo_q <= quo_fix;
                end
            end
        end
    end

    assign bus.ready = (state == S_IDLE);
    assign bus.busy  = (state != S_IDLE);
    assign bus.done  = (state == S_DONE);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: tb/tb_mdu_seq.sv
// Directed and randomized bench for mdu_seq; results come from a 64-bit arithmetic reference.
module tb_mdu_seq;
    logic clk    = 1'b0;
    logic resetn = 1'b0;

    mdu_seq_if #(.WIDTH(32)) bus ();
    mdu_seq #(.WIDTH(32)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Returns {hi, lo} from plain signed/unsigned arithmetic.
    function automatic logic [63:0] ref_mdu(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        logic [63:0]     ua, ub, res;
        logic [31:0]     mag_a;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        ua    = {32'd0, a};
        ub    = {32'd0, b};
        mag_a = a[31] ? -a : a;
        res   = '0;
        case (o)
            2'b00: res = 64'(sa * sb);
            2'b01: res = ua * ub;
            2'b10: begin
                if (b == 32'd0) begin
                    res = {mag_a, 32'hFFFF_FFFF};
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else            res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = o;
        bus.src_a = a;
        bus.src_b = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n, output int nb);
        n  = 0;
        nb = 0;
        while (bus.done !== 1'b1 && n < 60) begin
            if (bus.busy === 1'b1) nb++;
            @(negedge clk);
            n++;
        end
        if (bus.busy === 1'b1) nb++;
    endtask

    // Leaves the caller in the done cycle.
    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int          n, nb;
        logic [63:0] e;
        e = ref_mdu(o, a, b);
        go(o, a, b);
        wait_done(n, nb);
        chk({tag, " latency"}, 64'(n), 64'd33);
        chk({tag, " busy_cycles"}, 64'(nb), 64'd34);
        chk({tag, " hi"}, 64'(bus.hi), 64'(e[63:32]));
        chk({tag, " lo"}, 64'(bus.lo), 64'(e[31:0]));
    endtask

    initial begin
        int          n, nb, cnt;
        logic [1:0]  o;
        logic [31:0] a, b;
        logic [63:0] e;

        bus.start = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0;
        bus.cancel = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;

        #12;
        chk("rst ready", 64'(bus.ready), 64'd1);
        chk("rst busy",  64'(bus.busy),  64'd0);
        chk("rst done",  64'(bus.done),  64'd0);
        chk("rst hi",    64'(bus.hi),    64'd0);
        chk("rst lo",    64'(bus.lo),    64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        run("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'h0000_0003);
        @(negedge clk);
        chk("mult_neg done_pulse", 64'(bus.done), 64'd0);

        run("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        run("div_neg7", 2'b10, 32'hFFFF_FFF9, 32'd2);
        @(negedge clk);
        run("divu_zero", 2'b11, 32'd7, 32'd0);
        @(negedge clk);

        // Overflow divide, then start held through DONE is taken once back in IDLE.
        run("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'h0001_2345; bus.src_b = 32'h0000_1001;
        e = ref_mdu(2'b01, 32'h0001_2345, 32'h0000_1001);
        @(negedge clk);
        chk("b2b done_low", 64'(bus.done), 64'd0);
        chk("b2b idle_ready", 64'(bus.ready), 64'd1);
        @(negedge clk);
        chk("b2b accepted", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        wait_done(n, nb);
        chk("b2b latency", 64'(n), 64'd33);
        chk("b2b hi", 64'(bus.hi), 64'(e[63:32]));
        chk("b2b lo", 64'(bus.lo), 64'(e[31:0]));
        @(negedge clk);

        // Result write wins over MTHI/MTLO on the FIX edge.
        e = ref_mdu(2'b01, 32'hCAFE_0001, 32'h0BAD_F00D);
        go(2'b01, 32'hCAFE_0001, 32'h0BAD_F00D);
        repeat (32) @(negedge clk);
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        chk("fix_override done", 64'(bus.done), 64'd1);
        chk("fix_override hi", 64'(bus.hi), 64'(e[63:32]));
        chk("fix_override lo", 64'(bus.lo), 64'(e[31:0]));
        @(negedge clk);

        // MTHI/MTLO preload, then cancel a DIVU at iteration 10.
        bus.hi_we = 1'b1; bus.wdata = 32'h0000_1234;
        @(negedge clk);
        bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h0000_5678;
        @(negedge clk);
        bus.lo_we = 1'b0;
        chk("mthi hi", 64'(bus.hi), 64'h1234);
        chk("mtlo lo", 64'(bus.lo), 64'h5678);
        go(2'b11, 32'hFFFF_FFFF, 32'd3);
        repeat (10) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        chk("cancel busy", 64'(bus.busy), 64'd0);
        chk("cancel ready", 64'(bus.ready), 64'd1);
        cnt = 0;
        repeat (40) begin
            if (bus.done === 1'b1) cnt++;
            @(negedge clk);
        end
        chk("cancel no_done", 64'(cnt), 64'd0);
        chk("cancel hi", 64'(bus.hi), 64'h1234);
        chk("cancel lo", 64'(bus.lo), 64'h5678);

        bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 2'b00;
        @(negedge clk);
        bus.start = 1'b0; bus.cancel = 1'b0;
        chk("start_cancel busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk("start_cancel hi", 64'(bus.hi), 64'h1234);

        // Asynchronous reset between clock edges in the middle of CALC.
        go(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst busy", 64'(bus.busy), 64'd0);
        chk("async_rst ready", 64'(bus.ready), 64'd1);
        chk("async_rst hi", 64'(bus.hi), 64'd0);
        chk("async_rst lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // start while busy is ignored; the operands on the bus change too.
        e = ref_mdu(2'b10, 32'h8765_4321, 32'h0000_0123);
        go(2'b10, 32'h8765_4321, 32'h0000_0123);
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'h5555_5555; bus.src_b = 32'h7;
        repeat (5) @(negedge clk);
        bus.start = 1'b0;
        wait_done(n, nb);
        chk("busy_start latency", 64'(n), 64'd25);
        chk("busy_start hi", 64'(bus.hi), 64'(e[63:32]));
        chk("busy_start lo", 64'(bus.lo), 64'(e[31:0]));
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if (o[1]) b = b >> $urandom_range(0, 31);
            run($sformatf("rnd%0d op%0d", i, o), o, a, b);
            @(negedge clk);
            chk($sformatf("rnd%0d done_low", i), 64'(bus.done), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
